// File: rtl/pipe_sel_stage_if.sv
// Bus for pipe_sel_stage: channel inputs, select, pipeline controls and registered outputs.
// The master drives the channels and controls; the slave (the stage itself) drives out_*.
interface pipe_sel_stage_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4
);
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    stall;
    logic                    flush;
    logic                    err_clr;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;

    modport master (
        output in_data, sel, in_valid, stall, flush, err_clr,
        input  out_data, out_valid, out_sel, sel_err
    );

    modport slave (
        input  in_data, sel, in_valid, stall, flush, err_clr,
        output out_data, out_valid, out_sel, sel_err
    );
endinterface

// File: rtl/pipe_sel_stage.sv
// N-input selector feeding a DEPTH-deep register chain with stall, flush, per-stage valid
// tracking and a sticky out-of-range select flag.
module pipe_sel_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned DEPTH  = 1
) (
    input logic               clk,
    input logic               rst_n,
    pipe_sel_stage_if.slave   bus
);
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [WIDTH-1:0] mux;
    logic             sel_oor;
    logic             accept;

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [SEL_W-1:0] sel_q   [DEPTH];
    logic             valid_q [DEPTH];
    logic             sel_err_q;

    // Out-of-range selects match no channel and therefore yield zero.
    always_comb begin
        mux = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                mux = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_oor = (32'(bus.sel) >= NUM_IN);
    assign accept  = !bus.flush && !bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                sel_q[i]   <= '0;
                valid_q[i] <= 1'b0;
            end
        end else if (bus.flush) begin
            // Only the valid bits drop; data and sel are left as stale payload.
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (!bus.stall) begin
            data_q[0]  <= mux;
            sel_q[0]   <= bus.sel;
            valid_q[0] <= bus.in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                sel_q[i]   <= sel_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (accept && bus.in_valid && sel_oor) begin
            sel_err_q <= 1'b1;
        end else if (bus.err_clr) begin
            sel_err_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.out_sel   = sel_q[DEPTH-1];
    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_pipe_sel_stage.sv
// Self-checking bench for pipe_sel_stage: three configurations, queue-based scoreboards for
// the payload plus directed latency, stall, flush, sel_err and async-reset checks.
module tb_pipe_sel_stage;
    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    pipe_sel_stage_if #(.WIDTH(32), .NUM_IN(4))  ia ();
    pipe_sel_stage_if #(.WIDTH(32), .NUM_IN(3))  ib ();
    pipe_sel_stage_if #(.WIDTH(8),  .NUM_IN(16)) ic ();

    pipe_sel_stage #(.WIDTH(32), .NUM_IN(4), .DEPTH(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    pipe_sel_stage #(.WIDTH(32), .NUM_IN(3), .DEPTH(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    pipe_sel_stage #(.WIDTH(8),  .NUM_IN(16), .DEPTH(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    // Scoreboard entries are {sel, data}.
    logic [33:0] qb [$];
    logic [11:0] qc [$];
    logic        errb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic [31:0] c0, c1, c2, c3, input logic [1:0] s, input logic v);
        logic [31:0] ch [4];
        ch = '{c0, c1, c2, c3};
        ia.in_data  = {c3, c2, c1, c0};
        ia.sel      = s;
        ia.in_valid = v;
        @(posedge clk);
        #1;
        check("a_valid", 64'(ia.out_valid), 64'(v));
        if (v) begin
            check("a_data", 64'(ia.out_data), 64'(ch[s]));
            check("a_sel", 64'(ia.out_sel), 64'(s));
        end
        check("a_err", 64'(ia.sel_err), 64'd0);
    endtask

    task automatic step_b(input logic [31:0] c0, c1, c2, input logic [1:0] s,
                          input logic v, st, fl, ec);
        logic [31:0] ch [4];
        logic [33:0] e;
        ch = '{c0, c1, c2, 32'd0};
        ib.in_data  = {c2, c1, c0};
        ib.sel      = s;
        ib.in_valid = v;
        ib.stall    = st;
        ib.flush    = fl;
        ib.err_clr  = ec;
        @(posedge clk);
        #1;
        if (fl) begin
            qb.delete();
        end else if (!st && v) begin
            qb.push_back({s, ch[s]});
        end
        if (!fl && !st && v && s == 2'd3) begin
            errb = 1'b1;
        end else if (ec) begin
            errb = 1'b0;
        end
        if (!fl && !st && ib.out_valid) begin
            if (qb.size() == 0) begin
                check("b_unexpected_out", 64'(ib.out_data), 64'hDEAD);
            end else begin
                e = qb.pop_front();
                check("b_data", 64'(ib.out_data), 64'(e[31:0]));
                check("b_sel", 64'(ib.out_sel), 64'(e[33:32]));
            end
        end
        check("b_err", 64'(ib.sel_err), 64'(errb));
    endtask

    task automatic step_c(input logic [3:0] s, input logic v);
        logic [11:0] e;
        for (int j = 0; j < 16; j++) begin
            ic.in_data[j*8 +: 8] = {4'(j), 4'(s + 4'd3)};
        end
        ic.sel      = s;
        ic.in_valid = v;
        @(posedge clk);
        #1;
        if (v) begin
            qc.push_back({s, s, 4'(s + 4'd3)});
        end
        if (ic.out_valid) begin
            if (qc.size() == 0) begin
                check("c_unexpected_out", 64'(ic.out_data), 64'hDEAD);
            end else begin
                e = qc.pop_front();
                check("c_data", 64'(ic.out_data), 64'(e[7:0]));
                check("c_sel", 64'(ic.out_sel), 64'(e[11:8]));
            end
        end
        check("c_err", 64'(ic.sel_err), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        errb     = 1'b0;
        rst_n    = 1'b0;
        {ia.in_data, ia.sel, ia.in_valid, ia.stall, ia.flush, ia.err_clr} = '0;
        {ib.in_data, ib.sel, ib.in_valid, ib.stall, ib.flush, ib.err_clr} = '0;
        {ic.in_data, ic.sel, ic.in_valid, ic.stall, ic.flush, ic.err_clr} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", 64'(ia.out_valid), 64'd0);
        check("rst_b_data", 64'(ib.out_data), 64'd0);
        check("rst_b_sel", 64'(ib.out_sel), 64'd0);
        check("rst_b_err", 64'(ib.sel_err), 64'd0);
        check("rst_c_valid", 64'(ic.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-stage capture of channel 2, then a short random stream.
        step_a(32'h0, 32'h1111_0001, 32'hCAFE_0002, 32'h3333_0003, 2'd2, 1'b1);
        for (int n = 0; n < 8; n++) begin
            step_a($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) != 0));
        end

        // Three-deep latency with a two-cycle stall mid-stream.
        step_b(32'hA0, 32'hA1, 32'hA2, 2'd0, 1, 0, 0, 0);
        check("b_lat_e1", 64'(ib.out_valid), 64'd0);
        step_b(32'hB0, 32'hB1, 32'hB2, 2'd1, 1, 0, 0, 0);
        check("b_lat_e2", 64'(ib.out_valid), 64'd0);
        step_b(32'hC0, 32'hC1, 32'hC2, 2'd2, 1, 0, 0, 0);
        check("b_lat_e3", 64'(ib.out_valid), 64'd1);
        repeat (2) begin
            step_b(32'hEE, 32'hEE, 32'hEE, 2'd1, 1, 1, 0, 0);
            check("b_stall_valid", 64'(ib.out_valid), 64'd1);
            check("b_stall_data", 64'(ib.out_data), 64'hA0);
        end
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("b_after_stall_e1", 64'(ib.out_data), 64'hB1);
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("b_after_stall_e2", 64'(ib.out_data), 64'hC2);
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("b_drained_valid", 64'(ib.out_valid), 64'd0);

        // Flush beats a simultaneous stall and an out-of-range valid entry.
        step_b(32'hD0, 32'hD1, 32'hD2, 2'd1, 1, 0, 0, 0);
        step_b(32'hE0, 32'hE1, 32'hE2, 2'd2, 1, 0, 0, 0);
        step_b(32'hF0, 32'hF1, 32'hF2, 2'd0, 1, 0, 0, 0);
        step_b(32'h99, 32'h99, 32'h99, 2'd3, 1, 1, 1, 0);
        check("b_flush_e1", 64'(ib.out_valid), 64'd0);
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("b_flush_e2", 64'(ib.out_valid), 64'd0);
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("b_flush_e3", 64'(ib.out_valid), 64'd0);
        check("b_flush_err", 64'(ib.sel_err), 64'd0);

        // Sticky sel_err: set, clear, set-beats-clear, and no set from stalled selects.
        step_b(32'h11, 32'h22, 32'h33, 2'd3, 1, 0, 0, 0);
        check("b_err_set", 64'(ib.sel_err), 64'd1);
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 1);
        check("b_err_clr", 64'(ib.sel_err), 64'd0);
        step_b(32'h44, 32'h55, 32'h66, 2'd3, 1, 0, 0, 1);
        check("b_err_set_wins", 64'(ib.sel_err), 64'd1);
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 1);
        step_b(32'h77, 32'h77, 32'h77, 2'd3, 1, 1, 0, 0);
        check("b_err_stalled", 64'(ib.sel_err), 64'd0);
        repeat (3) step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("b_err_drain", 64'(qb.size()), 64'd0);

        // Random stream through the three-deep stage.
        for (int n = 0; n < 40; n++) begin
            step_b($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0));
        end
        repeat (3) step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("b_rand_drain", 64'(qb.size()), 64'd0);

        // Sixteen-way sweep.
        for (int k = 0; k < 16; k++) begin
            step_c(4'(k), 1'b1);
        end
        repeat (2) step_c(4'd0, 1'b0);
        check("c_drain", 64'(qc.size()), 64'd0);

        // Asynchronous reset mid-cycle with live entries and sel_err set.
        step_a(32'h1, 32'h5A5A_0001, 32'h2, 32'h3, 2'd1, 1'b1);
        step_b(32'h5A, 32'h5B, 32'h5C, 2'd0, 1, 0, 0, 0);
        step_b(32'h6A, 32'h6B, 32'h6C, 2'd1, 1, 0, 0, 0);
        step_b(32'h7A, 32'h7B, 32'h7C, 2'd3, 1, 0, 0, 0);
        check("pre_rst_valid", 64'(ib.out_valid), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_b_valid", 64'(ib.out_valid), 64'd0);
        check("arst_b_data", 64'(ib.out_data), 64'd0);
        check("arst_b_err", 64'(ib.sel_err), 64'd0);
        check("arst_a_valid", 64'(ia.out_valid), 64'd0);
        check("arst_a_data", 64'(ia.out_data), 64'd0);
        qb.delete();
        errb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step_b(32'h8A, 32'h8B, 32'h8C, 2'd2, 1, 0, 0, 0);
        check("post_rst_e1", 64'(ib.out_valid), 64'd0);
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("post_rst_e2", 64'(ib.out_valid), 64'd0);
        step_b(0, 0, 0, 2'd0, 0, 0, 0, 0);
        check("post_rst_e3", 64'(ib.out_valid), 64'd1);
        check("post_rst_drain", 64'(qb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
